// File: rtl/counter_unit.sv
// Loadable up/down counter with an enable prescaler, sticky wrap carry and a
// one-cycle wrap pulse; every output comes straight from a flop.
module counter_unit #(
    parameter int WIDTH          = 8,
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      up_down,
    input  logic                      load,
    input  logic [WIDTH-1:0]          load_value,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      carry_clear,
    output logic [WIDTH-1:0]          counter_value,
    output logic                      counter_carry,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0]          count_q, count_d;
    logic                      carry_q, carry_d;
    logic                      tick_q, tick_d;
    logic                      wrap;

    always_comb begin
        pcnt_d  = pcnt_q;
        count_d = count_q;
        wrap    = 1'b0;
        if (load) begin
            count_d = load_value;
            pcnt_d  = '0;
        end else if (enable) begin
            // >= rather than == so a live drop of prescale below pcnt steps at once
            if (pcnt_q >= prescale) begin
                pcnt_d = '0;
                if (up_down) begin
                    wrap    = (count_q == '1);
                    count_d = count_q + 1'b1;
                end else begin
                    wrap    = (count_q == '0);
                    count_d = count_q - 1'b1;
                end
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end
        tick_d  = wrap;
        carry_d = wrap ? 1'b1 : (carry_clear ? 1'b0 : carry_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q  <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            count_q <= count_d;
            carry_q <= carry_d;
            tick_q  <= tick_d;
        end
    end

    assign counter_value = count_q;
    assign counter_carry = carry_q;
    assign tick          = tick_q;

endmodule

// File: tb/tb_counter_unit.sv
// Directed scoreboard bench for counter_unit: stimulus queues the expected
// registered outputs for each edge, a monitor pops and compares after the edge.
module tb_counter_unit;

    logic       clk = 1'b0;
    logic       reset, enable, up_down, load, carry_clear;
    logic [7:0] load_value;
    logic [3:0] prescale;
    logic [7:0] counter_value;
    logic       counter_carry, tick;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] v;
        logic       c;
        logic       t;
        string      nm;
    } exp_t;

    exp_t sb[$];

    counter_unit #(.WIDTH(8), .PRESCALE_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value), .prescale(prescale),
        .carry_clear(carry_clear), .counter_value(counter_value),
        .counter_carry(counter_carry), .tick(tick)
    );

    always #5 clk = ~clk;

    // Drive one edge's inputs and queue what the outputs must show after it.
    task automatic cyc(input logic rst, input logic en, input logic ud,
                       input logic ld, input logic [7:0] lv, input logic [3:0] ps,
                       input logic cc, input logic [7:0] ev, input logic ec,
                       input logic et, input string nm);
        exp_t e;
        @(negedge clk);
        reset = rst; enable = en; up_down = ud; load = ld;
        load_value = lv; prescale = ps; carry_clear = cc;
        e.v = ev; e.c = ec; e.t = et; e.nm = nm;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (counter_value !== e.v || counter_carry !== e.c || tick !== e.t) begin
                    errors++;
                    $display("FAIL %s: got value=%h carry=%b tick=%b, expected value=%h carry=%b tick=%b",
                             e.nm, counter_value, counter_carry, tick, e.v, e.c, e.t);
                end
            end
        end
    end

    initial begin : stim
        reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0;
        load_value = '0; prescale = '0; carry_clear = 1'b0;

        //  rst en ud ld  lv     ps     cc  value  c  t
        cyc(1, 0, 1, 0, 8'h00, 4'd0, 0, 8'h00, 0, 0, "reset");
        cyc(0, 0, 1, 0, 8'h00, 4'd0, 0, 8'h00, 0, 0, "idle_hold");

        // Up wrap through FF
        cyc(0, 1, 1, 1, 8'hFD, 4'd0, 0, 8'hFD, 0, 0, "up_load_fd");
        cyc(0, 1, 1, 0, 8'h00, 4'd0, 0, 8'hFE, 0, 0, "up_fe");
        cyc(0, 1, 1, 0, 8'h00, 4'd0, 0, 8'hFF, 0, 0, "up_ff");
        cyc(0, 1, 1, 0, 8'h00, 4'd0, 0, 8'h00, 1, 1, "up_wrap_00");
        cyc(0, 1, 1, 0, 8'h00, 4'd0, 0, 8'h01, 1, 0, "up_01_sticky");

        // Down wrap through 00; carry_clear on the load cycle
        cyc(0, 1, 0, 1, 8'h01, 4'd0, 1, 8'h01, 0, 0, "dn_load_clear");
        cyc(0, 1, 0, 0, 8'h00, 4'd0, 0, 8'h00, 0, 0, "dn_00");
        cyc(0, 1, 0, 0, 8'h00, 4'd0, 0, 8'hFF, 1, 1, "dn_wrap_ff");
        cyc(0, 1, 0, 0, 8'h00, 4'd0, 0, 8'hFE, 1, 0, "dn_fe");

        // Prescale 3 with an enable gap
        cyc(0, 1, 1, 1, 8'h10, 4'd3, 1, 8'h10, 0, 0, "ps3_load");
        cyc(0, 1, 1, 0, 8'h00, 4'd3, 0, 8'h10, 0, 0, "ps3_e1");
        cyc(0, 1, 1, 0, 8'h00, 4'd3, 0, 8'h10, 0, 0, "ps3_e2");
        cyc(0, 1, 1, 0, 8'h00, 4'd3, 0, 8'h10, 0, 0, "ps3_e3");
        cyc(0, 1, 1, 0, 8'h00, 4'd3, 0, 8'h11, 0, 0, "ps3_e4_step");
        cyc(0, 1, 1, 0, 8'h00, 4'd3, 0, 8'h11, 0, 0, "ps3_e5");
        cyc(0, 1, 1, 0, 8'h00, 4'd3, 0, 8'h11, 0, 0, "ps3_e6");
        cyc(0, 1, 1, 0, 8'h00, 4'd3, 0, 8'h11, 0, 0, "ps3_e7");
        cyc(0, 1, 1, 0, 8'h00, 4'd3, 0, 8'h12, 0, 0, "ps3_e8_step");
        cyc(0, 1, 1, 0, 8'h00, 4'd3, 0, 8'h12, 0, 0, "ps3_e9");
        cyc(0, 0, 1, 0, 8'h00, 4'd3, 0, 8'h12, 0, 0, "ps3_gap1");
        cyc(0, 0, 1, 0, 8'h00, 4'd3, 0, 8'h12, 0, 0, "ps3_gap2");
        cyc(0, 1, 1, 0, 8'h00, 4'd3, 0, 8'h12, 0, 0, "ps3_e12");
        cyc(0, 1, 1, 0, 8'h00, 4'd3, 0, 8'h12, 0, 0, "ps3_e13");
        cyc(0, 1, 1, 0, 8'h00, 4'd3, 0, 8'h13, 0, 0, "ps3_e14_step");

        // Live prescale drop below pcnt
        cyc(0, 1, 1, 1, 8'h20, 4'd7, 0, 8'h20, 0, 0, "ps7_load");
        cyc(0, 1, 1, 0, 8'h00, 4'd7, 0, 8'h20, 0, 0, "ps7_p1");
        cyc(0, 1, 1, 0, 8'h00, 4'd7, 0, 8'h20, 0, 0, "ps7_p2");
        cyc(0, 1, 1, 0, 8'h00, 4'd7, 0, 8'h20, 0, 0, "ps7_p3");
        cyc(0, 1, 1, 0, 8'h00, 4'd1, 0, 8'h21, 0, 0, "ps_drop_step");
        cyc(0, 1, 1, 0, 8'h00, 4'd1, 0, 8'h21, 0, 0, "ps1_hold");
        cyc(0, 1, 1, 0, 8'h00, 4'd1, 0, 8'h22, 0, 0, "ps1_step");
        cyc(0, 1, 1, 0, 8'h00, 4'd1, 0, 8'h22, 0, 0, "ps1_hold2");
        cyc(0, 1, 1, 0, 8'h00, 4'd1, 0, 8'h23, 0, 0, "ps1_step2");

        // carry_clear loses to a same-edge wrap, then clears
        cyc(0, 1, 1, 1, 8'hFE, 4'd0, 1, 8'hFE, 0, 0, "cc_load_fe");
        cyc(0, 1, 1, 0, 8'h00, 4'd0, 0, 8'hFF, 0, 0, "cc_ff");
        cyc(0, 1, 1, 0, 8'h00, 4'd0, 1, 8'h00, 1, 1, "cc_set_wins");
        cyc(0, 1, 1, 0, 8'h00, 4'd0, 1, 8'h01, 0, 0, "cc_clears");

        // Direction change applies on the very next step
        cyc(0, 1, 0, 0, 8'h00, 4'd0, 0, 8'h00, 0, 0, "dir_down");
        cyc(0, 1, 1, 0, 8'h00, 4'd0, 0, 8'h01, 0, 0, "dir_up");

        // Reset beats load with carry set
        cyc(0, 1, 1, 1, 8'hFF, 4'd0, 0, 8'hFF, 0, 0, "rst_load_ff");
        cyc(0, 1, 1, 0, 8'h00, 4'd0, 0, 8'h00, 1, 1, "rst_wrap");
        cyc(0, 1, 1, 0, 8'h00, 4'd0, 0, 8'h01, 1, 0, "rst_mid");
        cyc(1, 1, 1, 1, 8'hAA, 4'd0, 0, 8'h00, 0, 0, "rst_over_load");

        // First step after reset needs prescale+1 enabled edges
        cyc(0, 1, 1, 0, 8'h00, 4'd2, 0, 8'h00, 0, 0, "post_rst_e1");
        cyc(0, 1, 1, 0, 8'h00, 4'd2, 0, 8'h00, 0, 0, "post_rst_e2");
        cyc(0, 1, 1, 0, 8'h00, 4'd2, 0, 8'h01, 0, 0, "post_rst_e3_step");
        cyc(0, 0, 1, 0, 8'h00, 4'd2, 0, 8'h01, 0, 0, "final_hold");

        @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_unit.md
# counter_unit

Counter stage that feeds the output mux, producing the `counter_value` and `counter_carry` operands consumed at its counter-value and counter-carry select positions. It is a loadable 8-bit up/down counter with a programmable enable prescaler, a sticky wrap carry and a one-cycle wrap pulse. All outputs are registered, so the mux sees stable values for a full cycle after every clock edge.

## Interface
- `WIDTH`, 8: counter width; `counter_value` and `load_value` width.
- `PRESCALE_WIDTH`, 4: width of the `prescale` input and the internal prescaler count.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset, sampled on `clk` rising edge.
- `enable`  in  1: count enable; low freezes the prescaler and counter.
- `up_down`  in  1: 1 = count up, 0 = count down.
- `load`  in  1: synchronous parallel load of `load_value`.
- `load_value`  in  WIDTH: value loaded into the counter.
- `prescale`  in  PRESCALE_WIDTH: counter steps once every `prescale+1` enabled cycles.
- `carry_clear`  in  1: clears sticky `counter_carry`.
- `counter_value`  out  WIDTH: current count, registered.
- `counter_carry`  out  1: sticky wrap flag, registered.
- `tick`  out  1: one-cycle pulse marking a wrap, registered.

## Operation
- Reset values: `counter_value`=0, `counter_carry`=0, `tick`=0, prescaler count `pcnt`=0.
- Priority per edge: `reset` > `load` > step > hold.
- Load: `counter_value`<=`load_value`, `pcnt`<=0, `tick`<=0; `counter_carry` is not set by a load. `enable` is ignored on a load cycle.
- Step condition: `enable`=1, `load`=0, `pcnt >= prescale`.
  - On a step, `pcnt`<=0 and the counter moves ±1, modulo 2^WIDTH.
- Enabled, no step: `pcnt`<=`pcnt`+1 and the counter holds.
- `enable`=0: `pcnt` and the counter hold.
- The `>=` compare makes a live decrease of `prescale` below the current `pcnt` step on the next enabled edge, with no 2^PRESCALE_WIDTH stall. `prescale`=0 steps every enabled cycle.
- Wrap: a step up from 2^WIDTH-1 to 0, or a step down from 0 to 2^WIDTH-1.
  - On a wrap, `counter_carry`<=1 and `tick`<=1.
  - `tick` is 0 on every edge without a wrap.
- `carry_clear`=1 clears `counter_carry` unless a wrap occurs on the same edge. Set wins.
- `carry_clear` together with `load`: carry clears and the load proceeds.
- `up_down` is sampled per step; a direction change takes effect on the next step with no extra latency.
- `reset` asserted mid-count returns all state to reset values on that edge, regardless of `load` or `enable`.

## Timing
- All outputs change only on the `clk` rising edge.
- Load latency: 1 cycle. `load_value` appears on `counter_value` after the edge where `load`=1.
- Step latency: 1 cycle. `tick` and `counter_carry` rise in the same cycle that `counter_value` shows the wrapped value.
- With constant `enable`=1 and `prescale`=P, steps occur every P+1 cycles.
  - The first step after reset or load occurs P+1 enabled edges later.
- `tick` high time is exactly one cycle per wrap. When `prescale`=0 and the counter wraps repeatedly, `tick` cannot be high on consecutive cycles for WIDTH ≥ 2.
- No combinational input-to-output paths.

## Test plan
- Reset then load 8'hFD, `up_down`=1, `prescale`=0, `enable`=1 -> `counter_value` reads FE, FF, 00, 01 on successive cycles. `tick`=1 only in the 00 cycle; `counter_carry` goes 1 at 00 and stays 1.
- Load 8'h01, `up_down`=0, `prescale`=0 -> reads 00, FF. `tick` and `counter_carry` assert with FF.
- `prescale`=3, load 8'h10, enable held -> value steps to 11 after 4 edges and 12 after 8. Dropping `enable` for 2 cycles mid-count delays the next step by exactly 2 cycles.
- Set `pcnt` to 3 under `prescale`=7, then write `prescale`=1 -> step on the next enabled edge, then every 2 cycles.
- Counter at FF counting up with `carry_clear`=1 on the wrap edge -> `counter_carry`=1. `carry_clear`=1 on the following edge -> `counter_carry`=0.
- Mid-count with `counter_carry`=1, assert `reset` together with `load`=1 and `load_value`=8'hAA -> `counter_value`=00, `counter_carry`=0, `tick`=0 next cycle.
